rv_control_fsm: RTL and testbench

Multi-cycle control sequencer for the RV32I minimum core. It accepts one instruction at a time from fetch over a valid/ready handshake and holds it in an instruction register. It classifies the opcode and walks the shared field-decode/ALU/memory datapath through DECODE, EXECUTE, MEM and WB. It owns the program counter and produces the per-state control strobes.

---
 rtl/rv_control_fsm.sv | 183 ++++++++++++++++++
 tb/tb_rv_control_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_control_fsm.sv
// rv_control_fsm: multi-cycle RV32I control sequencer.
// Holds one instruction in ir, walks FETCH/DECODE/EXECUTE/MEM/WB,
// owns the program counter and drives the per-state control strobes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | instr_ready=1, capture instruction on instr_valid
// DECODE  | classify opcode, present immediate format; trap illegal
// EXECUTE | resolve branch/jump target, pick MEM or WB path
// MEM     | hold mem_req until mem_ack
// WB      | register write-back (rd != x0) and retire
module rv_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic        branch_taken,
  input  logic [31:0] alu_result,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic [2:0]  imm_sel,
  output logic        alu_src_imm,
  output logic [31:0] pc,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH,
    C_LOAD, C_STORE, C_OPIMM, C_OP
  } class_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;

  class_t      cls;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        is_jump;
  logic        misaligned;

  // Only opcode and rd are needed here; the rest of ir feeds the shared
  // field decoder, and target bit 0 is always forced to zero.
  logic        unused_bits;
  assign unused_bits = ^{ir_q[31:12], alu_result[0]};

  assign target   = {alu_result[31:1], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;
  assign is_jump  = (cls == C_JAL) || (cls == C_JALR);
  // A jump, or a taken branch, to a non-word-aligned address traps.
  assign misaligned = (is_jump || ((cls == C_BRANCH) && branch_taken)) && target[1];
  assign pc = pc_q;

  // Opcode classification from the held instruction (all legal opcodes end in 2'b11).
  always_comb begin
    cls = C_ILL;
    case (ir_q[6:0])
      7'b0110111: cls = C_LUI;
      7'b0010111: cls = C_AUIPC;
      7'b1101111: cls = C_JAL;
      7'b1100111: cls = C_JALR;
      7'b1100011: cls = C_BRANCH;
      7'b0000011: cls = C_LOAD;
      7'b0100011: cls = C_STORE;
      7'b0010011: cls = C_OPIMM;
      7'b0110011: cls = C_OP;
      default:    cls = C_ILL;
    endcase
  end

  // State, pc and instruction registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state, next-pc and instruction capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (misaligned) begin
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end else begin
          case (cls)
            C_BRANCH: begin
              pc_d    = branch_taken ? target : pc_plus4;
              state_d = S_FETCH;
            end
            C_JAL, C_JALR: begin
              pc_d    = target;
              state_d = S_WB;
            end
            C_LOAD, C_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          if (cls == C_STORE) begin
            pc_d    = pc_plus4;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        // Jumps already loaded their target on leaving EXECUTE.
        if (!is_jump) pc_d = pc_plus4;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Control strobes decoded from state and the held instruction.
  always_comb begin
    instr_ready = (state_q == S_FETCH);
    mem_req     = (state_q == S_MEM);
    mem_we      = (state_q == S_MEM) && (cls == C_STORE);
    reg_we      = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
    retire      = (state_q == S_WB)
               || ((state_q == S_EXECUTE) && (cls == C_BRANCH) && !misaligned)
               || ((state_q == S_MEM) && (cls == C_STORE) && mem_ack);
    illegal     = ((state_q == S_DECODE) && (cls == C_ILL))
               || ((state_q == S_EXECUTE) && misaligned);
    imm_sel     = IMM_I;
    alu_src_imm = 1'b0;
    if (state_q != S_FETCH) begin
      case (cls)
        C_STORE:         imm_sel = IMM_S;
        C_BRANCH:        imm_sel = IMM_B;
        C_LUI, C_AUIPC:  imm_sel = IMM_U;
        C_JAL:           imm_sel = IMM_J;
        default:         imm_sel = IMM_I;
      endcase
      alu_src_imm = (cls != C_OP) && (cls != C_BRANCH) && (cls != C_ILL);
    end
  end

endmodule

// File: tb/tb_rv_control_fsm.sv
// tb_rv_control_fsm: randomized and directed checks of rv_control_fsm
// against a per-instruction timeline model built from the ISA rules.
module tb_rv_control_fsm;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  localparam int K_ILL = 0, K_LUI = 1, K_AUIPC = 2, K_JAL = 3, K_JALR = 4,
                 K_BRANCH = 5, K_LOAD = 6, K_STORE = 7, K_OPIMM = 8, K_OP = 9;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        branch_taken;
  logic [31:0] alu_result;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        reg_we;
  logic [2:0]  imm_sel;
  logic        alu_src_imm;
  logic [31:0] pc;
  logic        retire;
  logic        illegal;

  rv_control_fsm #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction),
    .branch_taken(branch_taken), .alu_result(alu_result), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .imm_sel(imm_sel),
    .alu_src_imm(alu_src_imm), .pc(pc), .retire(retire), .illegal(illegal)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // flags packed as {instr_ready, mem_req, mem_we, reg_we, retire, illegal}
  logic [5:0]  obs_f [16];
  logic [2:0]  obs_imm [16];
  logic        obs_src [16];
  logic [31:0] obs_pc0;

  logic [5:0]  exp_f [16];
  int          exp_fin;
  logic [2:0]  exp_imm;
  logic        exp_src;
  bit          exp_legal;
  logic [31:0] exp_next_pc;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] ins;
    bit          tk;
    logic [31:0] alu;
    int          w;
  } stim_t;

  // Reference: for one instruction, the cycle on which it finishes, which
  // strobes fire on which cycle, and where pc goes next.
  task automatic model(input logic [31:0] ins, input bit tk,
                       input logic [31:0] alu, input int w);
    int kind;
    logic [31:0] tgt;
    bit uses_t, bad, wr, memop, st;
    case (ins[6:0])
      7'b0110111: kind = K_LUI;
      7'b0010111: kind = K_AUIPC;
      7'b1101111: kind = K_JAL;
      7'b1100111: kind = K_JALR;
      7'b1100011: kind = K_BRANCH;
      7'b0000011: kind = K_LOAD;
      7'b0100011: kind = K_STORE;
      7'b0010011: kind = K_OPIMM;
      7'b0110011: kind = K_OP;
      default:    kind = K_ILL;
    endcase
    tgt    = {alu[31:1], 1'b0};
    uses_t = (kind == K_JAL) || (kind == K_JALR) || (kind == K_BRANCH && tk);
    bad    = (kind == K_ILL) || (uses_t && tgt[1]);
    memop  = (kind == K_LOAD) || (kind == K_STORE);
    st     = (kind == K_STORE);
    wr     = !(kind == K_BRANCH || kind == K_STORE || kind == K_ILL);
    exp_legal = (kind != K_ILL);
    if (kind == K_ILL)          exp_fin = 1;
    else if (bad)               exp_fin = 2;
    else if (kind == K_BRANCH)  exp_fin = 2;
    else if (kind == K_STORE)   exp_fin = 3 + w;
    else if (kind == K_LOAD)    exp_fin = 4 + w;
    else                        exp_fin = 3;
    for (int k = 0; k < 16; k++) begin
      bit rq, last;
      last = (k == exp_fin);
      rq = memop && !bad && (k >= 3) && (k <= 3 + w);
      exp_f[k] = {k == 0, rq, rq && st, last && wr && !bad && (ins[11:7] != 0),
                  last && !bad, last && bad};
    end
    if (bad)                                 exp_next_pc = model_pc + 4;
    else if (kind == K_BRANCH)               exp_next_pc = tk ? tgt : model_pc + 4;
    else if (kind == K_JAL || kind == K_JALR) exp_next_pc = tgt;
    else                                     exp_next_pc = model_pc + 4;
    case (kind)
      K_STORE:         exp_imm = 3'd1;
      K_BRANCH:        exp_imm = 3'd2;
      K_LUI, K_AUIPC:  exp_imm = 3'd3;
      K_JAL:           exp_imm = 3'd4;
      default:         exp_imm = 3'd0;
    endcase
    exp_src = !(kind == K_OP || kind == K_BRANCH);
  endtask

  // Drive one instruction through cycles 0..fin; inputs that should be
  // ignored in a given cycle get random values.
  task automatic exec_instr(input logic [31:0] ins, input bit tk,
                            input logic [31:0] alu, input int w, input int fin);
    for (int k = 0; k <= fin; k++) begin
      @(negedge clock);
      instr_valid  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      instruction  = (k == 0) ? ins : $urandom;
      branch_taken = (k == 2) ? tk : 1'($urandom_range(0, 1));
      alu_result   = (k == 2) ? alu : $urandom;
      if (k >= 3 && k <= 3 + w) mem_ack = (k == 3 + w);
      else                      mem_ack = 1'($urandom_range(0, 1));
      #1;
      obs_f[k]   = {instr_ready, mem_req, mem_we, reg_we, retire, illegal};
      obs_imm[k] = imm_sel;
      obs_src[k] = alu_src_imm;
      if (k == 0) obs_pc0 = pc;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      instr_valid = 1'($urandom_range(0, 1));
      instruction = $urandom;
      mem_ack     = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      alu_result  = $urandom;
    end
    @(negedge clock);
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if ({instr_ready, mem_req, mem_we, reg_we, retire, illegal} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_strobes got %b want 100000",
               {instr_ready, mem_req, mem_we, reg_we, retire, illegal});
    end
    n_checks++;
    if ({imm_sel, alu_src_imm} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_imm got %b want 0000", {imm_sel, alu_src_imm});
    end
    n_checks++;
    if (pc !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_pc got %h want %h", pc, RST_PC);
    end
    model_pc = RST_PC;
  endtask

  task automatic test_directed();
    stim_t tab[$];
    tab.push_back('{32'h00500093, 1'b0, 32'h0,         0}); // ADDI x1,x0,5
    tab.push_back('{32'h002081B3, 1'b0, 32'h0,         0}); // ADD x3,x1,x2
    tab.push_back('{32'h00000463, 1'b1, 32'h10,        0}); // BEQ taken
    tab.push_back('{32'h008000EF, 1'b0, 32'h8,         0}); // JAL back to 8
    tab.push_back('{32'h00000463, 1'b0, 32'h10,        0}); // BEQ not taken
    tab.push_back('{32'h0000A103, 1'b0, 32'h0,         3}); // LW, 3 wait cycles
    tab.push_back('{32'h0020A023, 1'b0, 32'h0,         0}); // SW, same-cycle ack
    tab.push_back('{32'hFFFFFFFF, 1'b0, 32'h0,         0}); // illegal word
    tab.push_back('{32'h000080E7, 1'b0, 32'h6,         0}); // JALR misaligned
    tab.push_back('{32'h008000EF, 1'b0, 32'hFFFFFFFC,  0}); // JAL to top
    tab.push_back('{32'h123452B7, 1'b0, 32'h0,         0}); // LUI, pc wraps
    tab.push_back('{32'h00001017, 1'b0, 32'h0,         0}); // AUIPC x0
    tab.push_back('{32'h008000EF, 1'b0, 32'h21,        0}); // JAL, bit0 dropped
    tab.push_back('{32'h00000463, 1'b1, 32'h2,         0}); // BEQ taken misaligned
    tab.push_back('{32'h0000A003, 1'b0, 32'h0,         0}); // LW x0, same-cycle ack
    foreach (tab[i]) begin
      model(tab[i].ins, tab[i].tk, tab[i].alu, tab[i].w);
      exec_instr(tab[i].ins, tab[i].tk, tab[i].alu, tab[i].w, exp_fin);
      n_checks++;
      if (obs_pc0 !== model_pc) begin
        n_fail++;
        $display("FAIL dir%0d_pc got %h want %h", i, obs_pc0, model_pc);
      end
      for (int k = 0; k <= exp_fin; k++) begin
        n_checks++;
        if (obs_f[k] !== exp_f[k]) begin
          n_fail++;
          $display("FAIL dir%0d_strobes cyc %0d ins %h got %b want %b",
                   i, k, tab[i].ins, obs_f[k], exp_f[k]);
        end
        if (exp_legal && (k == 1 || k == 2)) begin
          n_checks++;
          if ({obs_imm[k], obs_src[k]} !== {exp_imm, exp_src}) begin
            n_fail++;
            $display("FAIL dir%0d_imm cyc %0d got %b want %b",
                     i, k, {obs_imm[k], obs_src[k]}, {exp_imm, exp_src});
          end
        end
      end
      model_pc = exp_next_pc;
    end
  endtask

  task automatic test_random(input int n);
    logic [6:0] opc_tab [9];
    opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    for (int i = 0; i < n; i++) begin
      logic [31:0] r, a, ins;
      int sel, w;
      bit tk;
      r   = $urandom;
      sel = $urandom_range(0, 9);
      ins = r;
      if (sel < 9) ins[6:0] = opc_tab[sel];
      else if ($urandom_range(0, 1) == 1) ins[6:0] = 7'b1110011;
      else ins[6:0] = {r[6:2], 2'b01};
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1] = 1'b0;
      tk = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 4);
      model(ins, tk, a, w);
      exec_instr(ins, tk, a, w, exp_fin);
      n_checks++;
      if (obs_pc0 !== model_pc) begin
        n_fail++;
        $display("FAIL rnd%0d_pc got %h want %h", i, obs_pc0, model_pc);
      end
      for (int k = 0; k <= exp_fin; k++) begin
        n_checks++;
        if (obs_f[k] !== exp_f[k]) begin
          n_fail++;
          $display("FAIL rnd%0d_strobes cyc %0d ins %h got %b want %b",
                   i, k, ins, obs_f[k], exp_f[k]);
        end
        if (exp_legal && (k == 1 || k == 2)) begin
          n_checks++;
          if ({obs_imm[k], obs_src[k]} !== {exp_imm, exp_src}) begin
            n_fail++;
            $display("FAIL rnd%0d_imm cyc %0d got %b want %b",
                     i, k, {obs_imm[k], obs_src[k]}, {exp_imm, exp_src});
          end
        end
      end
      model_pc = exp_next_pc;
    end
  endtask

  task automatic test_reset_mid_mem();
    for (int k = 0; k <= 4; k++) begin
      @(negedge clock);
      instr_valid  = (k == 0);
      instruction  = 32'h0000A103;
      branch_taken = 1'b0;
      alu_result   = 32'h0;
      mem_ack      = (k == 4);
      reset        = (k == 4);
      #1;
      if (k >= 3) begin
        n_checks++;
        if ({mem_req, retire, reg_we} !== 3'b100) begin
          n_fail++;
          $display("FAIL midmem_wait cyc %0d got %b want 100", k, {mem_req, retire, reg_we});
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      reset       = 1'b0;
      mem_ack     = (k == 0);
      instr_valid = 1'b0;
      #1;
      n_checks++;
      if ({instr_ready, mem_req, mem_we, reg_we, retire, illegal} !== 6'b100000) begin
        n_fail++;
        $display("FAIL midmem_after cyc %0d got %b want 100000", k,
                 {instr_ready, mem_req, mem_we, reg_we, retire, illegal});
      end
      n_checks++;
      if (pc !== RST_PC) begin
        n_fail++;
        $display("FAIL midmem_pc got %h want %h", pc, RST_PC);
      end
    end
    model_pc = RST_PC;
  endtask

  task automatic test_idle_end();
    @(negedge clock);
    instr_valid = 1'b0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1 || pc !== model_pc) begin
      n_fail++;
      $display("FAIL idle_end got ready %b pc %h want ready 1 pc %h", instr_ready, pc, model_pc);
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instruction = '0;
    branch_taken = 1'b0; alu_result = '0; mem_ack = 1'b0;
    model_pc = RST_PC;
    test_reset();
    test_directed();
    test_reset_mid_mem();
    test_random(60);
    test_idle_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
